// File: rtl/nv_ram_fifo_pkg.sv
// Shared constants, pointer/count types and the read-issue rule for the 512x512 RAM FIFO controller.
package nv_ram_fifo_pkg;

  localparam int NV_DW        = 512;
  localparam int NV_AW        = 9;
  localparam int NV_DEPTH     = 512;
  localparam int NV_AFULL_LVL = 496;

  typedef logic [NV_AW-1:0] ptr_t;
  typedef logic [NV_AW:0]   cnt_t;

  // A new read may issue only while skid entries plus the read in flight, less this cycle's pop, stay below 2.
  function automatic logic issue_ok(input logic [1:0] held, input logic inflight, input logic pop);
    logic [2:0] w_sum;
    w_sum = {1'b0, held} + {2'b00, inflight} - {2'b00, pop};
    return (w_sum < 3'd2);
  endfunction

endpackage

// File: rtl/nv_ram_fifo_skid2.sv
// Two-entry output skid: captures RAM read data and presents the head as registered pop data.
module nv_ram_fifo_skid2 #(
  parameter int DW = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cap,
  input  logic [DW-1:0] i_cap_data,
  input  logic          i_rd_prdy,
  output logic          o_rd_pvld,
  output logic [DW-1:0] o_rd_pd,
  output logic          o_pop,
  output logic [1:0]    o_held
);

  logic          r_vld0;
  logic          r_vld1;
  logic [DW-1:0] r_d0;
  logic [DW-1:0] r_d1;
  logic          w_vld0;
  logic          w_vld1;
  logic [DW-1:0] w_d0;
  logic [DW-1:0] w_d1;

  assign o_pop     = r_vld0 & i_rd_prdy;
  assign o_rd_pvld = r_vld0;
  assign o_rd_pd   = r_d0;
  assign o_held    = {1'b0, r_vld0} + {1'b0, r_vld1};

  // Next skid state: apply the pop first, then steer the captured word to the first free slot.
  always_comb begin
    w_vld0 = r_vld0;
    w_vld1 = r_vld1;
    w_d0   = r_d0;
    w_d1   = r_d1;
    if (o_pop) begin
      w_vld0 = r_vld1;
      w_d0   = r_d1;
      w_vld1 = 1'b0;
    end else begin
      w_vld0 = r_vld0;
    end
    if (i_cap) begin
      if (!w_vld0) begin
        w_vld0 = 1'b1;
        w_d0   = i_cap_data;
      end else begin
        w_vld1 = 1'b1;
        w_d1   = i_cap_data;
      end
    end else begin
      w_vld1 = w_vld1;
    end
  end

  // Skid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld0 <= 1'b0;
      r_vld1 <= 1'b0;
      r_d0   <= {DW{1'b0}};
      r_d1   <= {DW{1'b0}};
    end else begin
      r_vld0 <= w_vld0;
      r_vld1 <= w_vld1;
      r_d0   <= w_d0;
      r_d1   <= w_d1;
    end
  end

endmodule

// File: rtl/nv_ram_fifo_ctrl_512x512.sv
// Valid/ready FIFO controller around a 512x512 two-port RAM with a prefetching 2-entry output skid.
// Optional almost-full output wr_afull is built when NV_RAM_FIFO_AFULL_EN is defined.
module nv_ram_fifo_ctrl_512x512
  import nv_ram_fifo_pkg::*;
#(
  parameter int DW        = NV_DW,
  parameter int AW        = NV_AW,
`ifdef NV_RAM_FIFO_AFULL_EN
  parameter int AFULL_LVL = NV_AFULL_LVL,
`endif
  parameter int DEPTH     = NV_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  input  logic [DW-1:0] ram_dout,
  input  logic [31:0]   pwrbus_ram_pd,
  output logic [31:0]   ram_pwrbus_ram_pd,
`ifdef NV_RAM_FIFO_AFULL_EN
  output logic          wr_afull,
`endif
  output logic [AW:0]   fifo_occ
);

  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_ZERO  = (AW+1)'(0);
  localparam logic [AW:0] L_ONE   = (AW+1)'(1);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_ram_cnt;
  logic [AW:0]   r_occ;
  logic          r_inflight;
  logic [AW:0]   w_ram_cnt_nxt;
  logic [AW:0]   w_occ_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_re;
  logic [1:0]    w_held;

  // ram_cnt holds only committed, not-yet-read words, so reads never reach an unwritten address.
  assign wr_prdy = (r_ram_cnt != L_DEPTH);
  assign w_push  = wr_pvld & wr_prdy & ~rst;
  assign w_re    = ~rst & (r_ram_cnt != L_ZERO) & issue_ok(w_held, r_inflight, w_pop);

  assign ram_we            = w_push;
  assign ram_wa            = r_wptr;
  assign ram_di            = wr_pd;
  assign ram_re            = w_re;
  assign ram_ra            = r_rptr;
  assign ram_pwrbus_ram_pd = pwrbus_ram_pd;
  assign fifo_occ          = r_occ;

  // Next RAM word count and total occupancy.
  always_comb begin
    w_ram_cnt_nxt = r_ram_cnt;
    w_occ_nxt     = r_occ;
    case ({w_push, w_re})
      2'b10:   w_ram_cnt_nxt = r_ram_cnt + L_ONE;
      2'b01:   w_ram_cnt_nxt = r_ram_cnt - L_ONE;
      default: w_ram_cnt_nxt = r_ram_cnt;
    endcase
    case ({w_push, w_pop})
      2'b10:   w_occ_nxt = r_occ + L_ONE;
      2'b01:   w_occ_nxt = r_occ - L_ONE;
      default: w_occ_nxt = r_occ;
    endcase
  end

  // Pointers, counts and the read-in-flight flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= {AW{1'b0}};
      r_rptr     <= {AW{1'b0}};
      r_ram_cnt  <= L_ZERO;
      r_occ      <= L_ZERO;
      r_inflight <= 1'b0;
    end else begin
      r_wptr     <= w_push ? r_wptr + {{(AW-1){1'b0}}, 1'b1} : r_wptr;
      r_rptr     <= w_re   ? r_rptr + {{(AW-1){1'b0}}, 1'b1} : r_rptr;
      r_ram_cnt  <= w_ram_cnt_nxt;
      r_occ      <= w_occ_nxt;
      r_inflight <= w_re;
    end
  end

`ifdef NV_RAM_FIFO_AFULL_EN
  logic r_afull;

  // Almost-full reflects occupancy after this cycle's push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_afull <= 1'b0;
    end else begin
      r_afull <= (w_occ_nxt >= (AW+1)'(AFULL_LVL));
    end
  end

  assign wr_afull = r_afull;
`endif

  nv_ram_fifo_skid2 #(
    .DW (DW)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .i_cap      (r_inflight),
    .i_cap_data (ram_dout),
    .i_rd_prdy  (rd_prdy),
    .o_rd_pvld  (rd_pvld),
    .o_rd_pd    (rd_pd),
    .o_pop      (w_pop),
    .o_held     (w_held)
  );

endmodule
